mul8_acc_stage: RTL and testbench

MUL8_ACC_STAGE -- requirements
Module: mul8_acc_stage

---
 rtl/mul8_acc_pkg.sv | 15 +
 rtl/mul8_acc_add.sv | 33 +++
 rtl/mul8_acc_stage.sv | 80 ++++++++
 tb/tb_mul8_acc_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul8_acc_pkg.sv
// Shared types and constants for the mul8 product accumulator stage.
// Optional build macro MUL8_ACC_SAT_EN (saturating accumulate) is consumed by mul8_acc_add.
package mul8_acc_pkg;

   localparam int DEF_LEN   = 16;
   localparam int DEF_ACC_W = 24;
   localparam int PROD_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } acc_state_e;

endpackage

// File: rtl/mul8_acc_add.sv
// Combinational accumulate step: adds a product to the running sum and tracks group overflow.
// Define MUL8_ACC_SAT_EN to clamp the sum at all-ones on carry-out instead of wrapping.
module mul8_acc_add
   import mul8_acc_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic              ovf,
   input  logic              start,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_ovf
);

   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   raw;
   logic             carry;

   // A new group starts from zero with a clean overflow flag.
   assign base    = start ? '0 : acc;
   assign raw     = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign carry   = raw[ACC_W];
   assign sum_ovf = (ovf && !start) || carry;

`ifdef MUL8_ACC_SAT_EN
   // Once clamped, any further add carries again, so the sum stays pinned.
   assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul8_acc_stage.sv
// Groups LEN unsigned 16-bit products into one ACC_W-bit sum with a sticky overflow flag.
// Build macro MUL8_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mul8_acc_stage
   import mul8_acc_pkg::*;
#(
   parameter int LEN   = DEF_LEN,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   localparam int              CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   acc_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc, add_sum;
   logic             acc_ovf, add_ovf;
   logic             take, last_beat, start;

   // Handshake flags come straight from the state register.
   assign in_ready  = (state != ST_HOLD);
   assign out_valid = (state == ST_HOLD);
   assign take      = in_valid && in_ready;
   assign last_beat = take && (cnt == LAST);
   assign start     = (state == ST_IDLE);

   mul8_acc_add #(.ACC_W(ACC_W)) u_add (
      .acc     (acc),
      .ovf     (acc_ovf),
      .start   (start),
      .prod    (in_prod),
      .sum     (add_sum),
      .sum_ovf (add_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take) state_nxt = last_beat ? ST_HOLD : ST_ACC;
         ST_ACC:  if (last_beat) state_nxt = ST_HOLD;
         ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         acc_ovf <= 1'b0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else if (take) begin
         acc     <= add_sum;
         acc_ovf <= add_ovf;
         if (last_beat) begin
            cnt     <= '0;
            out_sum <= add_sum;
            out_ovf <= add_ovf;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mul8_acc_stage.sv
// Directed bench for mul8_acc_stage across LEN/ACC_W variants; honours MUL8_ACC_SAT_EN.
module tb_mul8_acc_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // a: LEN=4/ACC_W=24, b: LEN=2/ACC_W=16, c: LEN=3/ACC_W=24, d: LEN=1/ACC_W=24
   logic a_iv = 0, a_ir, a_ov, a_ordy = 0, a_ovf;
   logic [15:0] a_ip = '0;
   logic [23:0] a_sum;
   logic b_iv = 0, b_ir, b_ov, b_ordy = 0, b_ovf;
   logic [15:0] b_ip = '0;
   logic [15:0] b_sum;
   logic c_iv = 0, c_ir, c_ov, c_ordy = 0, c_ovf;
   logic [15:0] c_ip = '0;
   logic [23:0] c_sum;
   logic d_iv = 0, d_ir, d_ov, d_ordy = 0, d_ovf;
   logic [15:0] d_ip = '0;
   logic [23:0] d_sum;

   mul8_acc_stage #(.LEN(4), .ACC_W(24)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_prod(a_ip),
      .out_valid(a_ov), .out_ready(a_ordy), .out_sum(a_sum), .out_ovf(a_ovf));
   mul8_acc_stage #(.LEN(2), .ACC_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_prod(b_ip),
      .out_valid(b_ov), .out_ready(b_ordy), .out_sum(b_sum), .out_ovf(b_ovf));
   mul8_acc_stage #(.LEN(3), .ACC_W(24)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_prod(c_ip),
      .out_valid(c_ov), .out_ready(c_ordy), .out_sum(c_sum), .out_ovf(c_ovf));
   mul8_acc_stage #(.LEN(1), .ACC_W(24)) u_d (
      .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in_prod(d_ip),
      .out_valid(d_ov), .out_ready(d_ordy), .out_sum(d_sum), .out_ovf(d_ovf));

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic a_beat(input logic [15:0] p);
      a_iv = 1'b1; a_ip = p; step(); a_iv = 1'b0;
   endtask

   task automatic test_reset();
      step();
      n_tests++;
      if (a_ov !== 1'b0 || a_sum !== 24'd0 || a_ovf !== 1'b0)
         begin n_fail++; $display("FAIL reset_out: got v=%b s=%0d o=%b want 0/0/0", a_ov, a_sum, a_ovf); end
      rst_n = 1'b1;
      step();
      n_tests++;
      if ({a_ir, b_ir, c_ir, d_ir} !== 4'b1111)
         begin n_fail++; $display("FAIL reset_ready: got %b want 1111", {a_ir, b_ir, c_ir, d_ir}); end
   endtask

   task automatic test_basic();
      a_beat(16'd1); a_beat(16'd2); a_beat(16'd3);
      a_iv = 1'b1; a_ip = 16'd4;
      n_tests++;
      if (a_ov !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", a_ov); end
      step(); a_iv = 1'b0;
      n_tests++;
      if (a_ov !== 1'b1 || a_sum !== 24'd10 || a_ovf !== 1'b0)
         begin n_fail++; $display("FAIL basic_result: got v=%b s=%0d o=%b want 1/10/0", a_ov, a_sum, a_ovf); end
      a_ordy = 1'b1; step(); a_ordy = 1'b0;
      n_tests++;
      if (a_ov !== 1'b0 || a_ir !== 1'b1)
         begin n_fail++; $display("FAIL basic_release: got v=%b r=%b want 0/1", a_ov, a_ir); end
   endtask

   task automatic test_overflow();
      logic [15:0] want;
`ifdef MUL8_ACC_SAT_EN
      want = 16'hFFFF;
`else
      want = 16'hFFFE;
`endif
      b_iv = 1'b1; b_ip = 16'hFFFF; step(); step(); b_iv = 1'b0;
      n_tests++;
      if (b_ov !== 1'b1 || b_sum !== want || b_ovf !== 1'b1)
         begin n_fail++; $display("FAIL ovf_result: got v=%b s=%h o=%b want 1/%h/1", b_ov, b_sum, b_ovf, want); end
      b_ordy = 1'b1; step(); b_ordy = 1'b0;
      // A clean group afterwards must not inherit the sticky flag.
      b_iv = 1'b1; b_ip = 16'd3; step(); b_ip = 16'd5; step(); b_iv = 1'b0;
      n_tests++;
      if (b_ov !== 1'b1 || b_sum !== 16'd8 || b_ovf !== 1'b0)
         begin n_fail++; $display("FAIL ovf_clear: got v=%b s=%0d o=%b want 1/8/0", b_ov, b_sum, b_ovf); end
      b_ordy = 1'b1; step(); b_ordy = 1'b0;
   endtask

   task automatic test_hold();
      a_beat(16'd10); a_beat(16'd20); a_beat(16'd30); a_beat(16'd40);
      a_iv = 1'b1; a_ip = 16'd99;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (a_ov !== 1'b1 || a_sum !== 24'd100 || a_ir !== 1'b0)
            begin n_fail++; $display("FAIL hold_cycle%0d: got v=%b s=%0d r=%b want 1/100/0", i, a_ov, a_sum, a_ir); end
         step();
      end
      a_iv = 1'b0; a_ordy = 1'b1; step(); a_ordy = 1'b0;
      n_tests++;
      if (a_ov !== 1'b0) begin n_fail++; $display("FAIL hold_exit: got %b want 0", a_ov); end
      a_beat(16'd1); a_beat(16'd1); a_beat(16'd1); a_beat(16'd1);
      n_tests++;
      if (a_ov !== 1'b1 || a_sum !== 24'd4)
         begin n_fail++; $display("FAIL hold_no_consume: got v=%b s=%0d want 1/4", a_ov, a_sum); end
      a_ordy = 1'b1; step(); a_ordy = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_beat(16'd5); a_beat(16'd7);
      rst_n = 1'b0; step();
      n_tests++;
      if (a_ov !== 1'b0 || a_sum !== 24'd0 || a_ovf !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_clear: got v=%b s=%0d o=%b want 0/0/0", a_ov, a_sum, a_ovf); end
      rst_n = 1'b1; step();
      a_beat(16'd1); a_beat(16'd1); a_beat(16'd1);
      n_tests++;
      if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_early: got %b want 0", a_ov); end
      a_beat(16'd1);
      n_tests++;
      if (a_ov !== 1'b1 || a_sum !== 24'd4)
         begin n_fail++; $display("FAIL rstmid_sum: got v=%b s=%0d want 1/4", a_ov, a_sum); end
      a_ordy = 1'b1; step(); a_ordy = 1'b0;
   endtask

   task automatic test_gaps();
      logic [15:0] v [3];
      v[0] = 16'd2; v[1] = 16'd3; v[2] = 16'd4;
      for (int i = 0; i < 3; i++) begin
         c_iv = 1'b1; c_ip = v[i]; step(); c_iv = 1'b0;
         if (i < 2) begin
            step(); step();
            n_tests++;
            if (c_ov !== 1'b0) begin n_fail++; $display("FAIL gaps_early%0d: got %b want 0", i, c_ov); end
         end
      end
      n_tests++;
      if (c_ov !== 1'b1 || c_sum !== 24'd9 || c_ovf !== 1'b0)
         begin n_fail++; $display("FAIL gaps_sum: got v=%b s=%0d o=%b want 1/9/0", c_ov, c_sum, c_ovf); end
      c_ordy = 1'b1; step(); c_ordy = 1'b0;
   endtask

   task automatic test_len1();
      d_iv = 1'b1; d_ip = 16'h1234; step(); d_iv = 1'b0;
      n_tests++;
      if (d_ov !== 1'b1 || d_sum !== 24'h1234 || d_ir !== 1'b0)
         begin n_fail++; $display("FAIL len1: got v=%b s=%h r=%b want 1/1234/0", d_ov, d_sum, d_ir); end
      d_ordy = 1'b1; step(); d_ordy = 1'b0;
      n_tests++;
      if (d_ov !== 1'b0 || d_ir !== 1'b1)
         begin n_fail++; $display("FAIL len1_exit: got v=%b r=%b want 0/1", d_ov, d_ir); end
   endtask

   task automatic test_back_to_back();
      a_beat(16'd1); a_beat(16'd1); a_beat(16'd1); a_beat(16'd1);
      // HOLD exit and a pending beat in the same cycle: the beat must wait one cycle.
      a_ordy = 1'b1; a_iv = 1'b1; a_ip = 16'd8; step(); a_ordy = 1'b0;
      n_tests++;
      if (a_ov !== 1'b0 || a_ir !== 1'b1)
         begin n_fail++; $display("FAIL b2b_exit: got v=%b r=%b want 0/1", a_ov, a_ir); end
      step(); a_iv = 1'b0;
      a_beat(16'd1); a_beat(16'd1);
      n_tests++;
      if (a_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b want 0", a_ov); end
      a_beat(16'd1);
      n_tests++;
      if (a_ov !== 1'b1 || a_sum !== 24'd11)
         begin n_fail++; $display("FAIL b2b_sum: got v=%b s=%0d want 1/11", a_ov, a_sum); end
      a_ordy = 1'b1; step(); a_ordy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_hold();
      test_reset_mid();
      test_gaps();
      test_len1();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
